mips_multicycle_ctrl: RTL and testbench

- Moore-style main controller that sequences a multicycle MIPS datapath: instruction fetch, decode, execute, memory and writeback over several clocks per instruction.
- Drives every datapath enable and mux select, and gates PC update using the ALU zero flag.
- Sits beside the datapath. Decodes opcode from the instruction register.
- Emits per-instruction completion and illegal-opcode status for the testbench and debug.

---
 rtl/mips_multicycle_ctrl_if.sv | 46 ++++
 rtl/mips_multicycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS main controller and its datapath.
// Optional macro: MIPS_MC_CTRL_MEM_WAIT_EN adds the mem_ready handshake input.
interface mips_multicycle_ctrl_if;
   logic [5:0] opcode;
   logic       zero;
`ifdef MIPS_MC_CTRL_MEM_WAIT_EN
   logic       mem_ready;
`endif
   logic       PCEn;
   logic [1:0] PCSrc;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [3:0] state;
   logic       instr_done;
   logic       illegal_op;

   // Controller side
   modport master (
`ifdef MIPS_MC_CTRL_MEM_WAIT_EN
      input  mem_ready,
`endif
      input  opcode, zero,
      output PCEn, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegDst,
             MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, state,
             instr_done, illegal_op
   );

   // Datapath side
   modport slave (
`ifdef MIPS_MC_CTRL_MEM_WAIT_EN
      output mem_ready,
`endif
      output opcode, zero,
      input  PCEn, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegDst,
             MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, state,
             instr_done, illegal_op
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style main controller for a multicycle MIPS datapath.
// Optional macro: MIPS_MC_CTRL_MEM_WAIT_EN makes FETCH, MEMRD and MEMWR wait
// for mem_ready; without it memory is treated as single-cycle.
module mips_multicycle_ctrl #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_ADDI  = 6'b001000,
   parameter logic [5:0] OP_J     = 6'b000010
) (
   input  logic                   clk,
   input  logic                   rst,
   mips_multicycle_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;

   state_t     state_q, state_d;
   logic       mem_rdy;

   logic       pc_en, iord, mem_read, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic       instr_done, illegal_op;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic [3:0] state_o;

`ifdef MIPS_MC_CTRL_MEM_WAIT_EN
   assign mem_rdy = bus.mem_ready;
`else
   assign mem_rdy = 1'b1;
`endif

   // State register with synchronous reset to FETCH
   always_ff @(posedge clk) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   // Next-state and control decode; reset blanks every output
   always_comb begin
      state_d    = FETCH;
      pc_en      = 1'b0;
      pc_src     = 2'b00;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      state_o    = state_q;

      case (state_q)
         FETCH: begin
            mem_read  = 1'b1;
            ir_write  = mem_rdy;
            alu_src_b = 2'b01;
            pc_en     = mem_rdy;
            state_d   = mem_rdy ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (bus.opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default: begin
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
                  state_d    = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            state_d  = mem_rdy ? MEMWB : MEMRD;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
         end
         MEMWR: begin
            mem_write  = 1'b1;
            iord       = 1'b1;
            instr_done = mem_rdy;
            state_d    = mem_rdy ? FETCH : MEMWR;
         end
         EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = ALUWB;
         end
         ALUWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
         end
         BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            pc_src     = 2'b01;
            pc_en      = bus.zero;
            instr_done = 1'b1;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = ADDIWB;
         end
         ADDIWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         JUMP: begin
            pc_src     = 2'b10;
            pc_en      = 1'b1;
            instr_done = 1'b1;
         end
         default: state_d = FETCH;
      endcase

      if (rst) begin
         pc_en      = 1'b0;
         pc_src     = 2'b00;
         iord       = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         reg_write  = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         alu_op     = 2'b00;
         instr_done = 1'b0;
         illegal_op = 1'b0;
         state_o    = 4'd0;
      end
   end

   assign bus.PCEn       = pc_en;
   assign bus.PCSrc      = pc_src;
   assign bus.IorD       = iord;
   assign bus.MemRead    = mem_read;
   assign bus.MemWrite   = mem_write;
   assign bus.IRWrite    = ir_write;
   assign bus.RegDst     = reg_dst;
   assign bus.MemtoReg   = mem_to_reg;
   assign bus.RegWrite   = reg_write;
   assign bus.ALUSrcA    = alu_src_a;
   assign bus.ALUSrcB    = alu_src_b;
   assign bus.ALUOp      = alu_op;
   assign bus.state      = state_o;
   assign bus.instr_done = instr_done;
   assign bus.illegal_op = illegal_op;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl against an instruction-level model.
// Honours MIPS_MC_CTRL_MEM_WAIT_EN when defined at compile time.
module tb_mips_multicycle_ctrl;
   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   int   path[$];

   mips_multicycle_ctrl_if bus();

   mips_multicycle_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [16:0] dut_ctrl;
   assign dut_ctrl = {bus.PCEn, bus.PCSrc, bus.IorD, bus.MemRead, bus.MemWrite,
                      bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
                      bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.instr_done,
                      bus.illegal_op};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      return op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == J;
   endfunction

   function automatic int lat_of(input logic [5:0] op);
      case (op)
         LW:                 return 5;
         SW, RT, ADDI:       return 4;
         BEQ, J:             return 3;
         default:            return 2;
      endcase
   endfunction

   // Sequence of states visited by each instruction class
   task automatic set_path(input logic [5:0] op);
      path.delete();
      path.push_back(0);
      path.push_back(1);
      case (op)
         LW:      begin path.push_back(2); path.push_back(3); path.push_back(4); end
         SW:      begin path.push_back(2); path.push_back(5); end
         RT:      begin path.push_back(6); path.push_back(7); end
         BEQ:     path.push_back(8);
         ADDI:    begin path.push_back(9); path.push_back(10); end
         J:       path.push_back(11);
         default: ;
      endcase
   endtask

   // Expected control word for a given state as listed in the state table
   function automatic logic [16:0] exp_ctrl(input int s, input logic [5:0] op,
                                             input logic z, input logic rdy);
      logic pcen, iord, mr, mw, irw, rd, m2r, rw, asa, done, ill;
      logic [1:0] pcs, asb, aop;
      {pcen, iord, mr, mw, irw, rd, m2r, rw, asa, done, ill} = '0;
      {pcs, asb, aop} = '0;
      case (s)
         0:  begin mr = 1; irw = rdy; asb = 2'b01; pcen = rdy; end
         1:  begin asb = 2'b11; if (!is_legal(op)) begin ill = 1; done = 1; end end
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mr = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; done = 1; end
         5:  begin mw = 1; iord = 1; done = rdy; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rw = 1; rd = 1; done = 1; end
         8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pcen = z; done = 1; end
         9:  begin asa = 1; asb = 2'b10; end
         10: begin rw = 1; done = 1; end
         11: begin pcs = 2'b10; pcen = 1; done = 1; end
         default: ;
      endcase
      return {pcen, pcs, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, done, ill};
   endfunction

   task automatic reset_cycle();
      rst = 1'b1;
      @(negedge clk);
      check("rst_ctrl", 32'(dut_ctrl), 32'd0);
      check("rst_state", 32'(bus.state), 32'd0);
      @(posedge clk); #1;
   endtask

   // Run one instruction; zmode 0/1 fixes zero, 2 randomizes; rst_at aborts at that path index
   task automatic run_instr(input logic [5:0] op, input int zmode, input int rst_at);
      int idx = 0, waits = 0, cyc = 0, done_cyc = 0, es;
      bit fin = 0, aborted = 0, r;
      logic rdy, z;
      logic [16:0] ec;
      bus.opcode = op;
      set_path(op);
      while (!fin) begin
         es  = path[idx];
         r   = (rst_at == idx);
         z   = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         rdy = 1'b1;
`ifdef MIPS_MC_CTRL_MEM_WAIT_EN
         rdy = ($urandom_range(0, 2) != 0);
         bus.mem_ready = rdy;
`endif
         rst = r;
         bus.zero = z;
         cyc++;
         @(negedge clk);
         ec = r ? '0 : exp_ctrl(es, op, z, rdy);
         check("ctrl", 32'(dut_ctrl), 32'(ec));
         check("state", 32'(bus.state), r ? 32'd0 : 32'(es));
         check("rd_wr_excl", 32'(bus.MemRead & bus.MemWrite), 32'd0);
         if (bus.instr_done) done_cyc = cyc;
         @(posedge clk); #1;
         if (r) begin
            rst = 1'b0;
            aborted = 1;
            fin = 1;
         end else if ((es == 0 || es == 3 || es == 5) && !rdy) begin
            waits++;
         end else begin
            idx++;
            if (idx == path.size()) fin = 1;
         end
         if (cyc > 200) begin
            check("timeout", 32'(cyc), 32'd200);
            fin = 1;
         end
      end
      if (!aborted) check("latency", 32'(done_cyc), 32'(lat_of(op) + waits));
   endtask

   initial begin
      logic [5:0] op;
      rst = 1'b1;
      bus.opcode = '0;
      bus.zero = 1'b0;
`ifdef MIPS_MC_CTRL_MEM_WAIT_EN
      bus.mem_ready = 1'b1;
`endif
      @(posedge clk); #1;
      reset_cycle();
      reset_cycle();
      rst = 1'b0;

      run_instr(LW, 0, -1);
      run_instr(BEQ, 1, -1);
      run_instr(BEQ, 0, -1);
      run_instr(SW, 2, -1);
      run_instr(RT, 2, -1);
      run_instr(6'b111111, 2, -1);
      run_instr(SW, 2, 2);
      run_instr(ADDI, 2, -1);
      run_instr(J, 2, -1);

      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 7))
            0: op = LW;
            1: op = SW;
            2: op = RT;
            3: op = BEQ;
            4: op = ADDI;
            5: op = J;
            default: begin
               op = 6'($urandom);
               while (is_legal(op)) op = 6'($urandom);
            end
         endcase
         set_path(op);
         run_instr(op, 2, ($urandom_range(0, 9) == 0) ?
                   int'($urandom_range(0, path.size() - 1)) : -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
